// File: rtl/mio_uart_tx_if.sv
// Bus-side signal bundle between the MIO bus decoder (master) and the UART TX peripheral (slave).
// Latency: none, wires only.
// Backpressure: none; writes into a full FIFO are dropped and flagged by the peripheral.
// Signals: uart_we/uart_wdata byte write strobe, ovf_clr sticky-overflow clear,
//          tx serial line, tx_busy activity flag, status_out 32-bit read-back word.
interface mio_uart_tx_if;
    logic        uart_we;
    logic [7:0]  uart_wdata;
    logic        ovf_clr;
    logic        tx;
    logic        tx_busy;
    logic [31:0] status_out;

    modport master (
        output uart_we, uart_wdata, ovf_clr,
        input  tx, tx_busy, status_out
    );

    modport slave (
        input  uart_we, uart_wdata, ovf_clr,
        output tx, tx_busy, status_out
    );
endinterface

// File: rtl/mio_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 LSB-first serialiser on the tx pin.
// Latency: FIFO pop to start bit is 1 cycle; frame is 10*DIV cycles (11*DIV with parity) + 1 idle.
// Backpressure: none; a write while full (and not popping) is dropped and sets sticky ovf.
// Ports: clk, rst (sync, active-high); bus = mio_uart_tx_if.slave carrying uart_we,
//        uart_wdata, ovf_clr in and tx, tx_busy, status_out out.
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit and advertise it on status bit 12.
module mio_uart_tx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    mio_uart_tx_if.slave bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic       PAR_ADV  = 1'b1;
`else
    localparam logic       PAR_ADV  = 1'b0;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [2:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic [31:0]   r_status;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic       w_tick;
    logic       w_active;
    logic       w_busy;
    logic [3:0] w_cnt4;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_FULL);
    // The serialiser only pulls a byte while idle.
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    // A pop in the same cycle frees a slot, so a write while full is still accepted.
    assign w_push   = bus.uart_we && (!w_full || w_pop);
    assign w_drop   = bus.uart_we && w_full && !w_pop;
    assign w_tick   = (r_baud == BAUD_LAST);
    assign w_active = (r_state != S_IDLE);
    assign w_busy   = w_active || !w_empty;
    assign w_cnt4   = 4'(r_count);

    // Storage array: contents are don't-care after reset since count/pointers are cleared.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= bus.uart_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            // Set has priority over clear when both happen in one cycle.
            if (w_drop)           r_ovf <= 1'b1;
            else if (bus.ovf_clr) r_ovf <= 1'b0;
        end
    end

    // r_tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^r_mem[r_rptr];
`endif
                        r_bit   <= '0;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Status word lags live state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= {19'b0, PAR_ADV, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        end else begin
            r_status <= {19'b0, PAR_ADV, 1'b0, w_cnt4, r_ovf, w_active, w_full, w_empty, w_busy, 2'b00};
        end
    end

    assign bus.tx         = r_tx;
    assign bus.tx_busy    = w_busy;
    assign bus.status_out = r_status;
endmodule

// File: tb/tb_mio_uart_tx.sv
// Directed bench for mio_uart_tx with DIV=10, FIFO_DEPTH=4.
// Per-cycle vector tables drive inputs and check outputs; a frame decoder runs alongside.
// Status word layout: [10:7] count, 6 ovf, 5 active, 4 full, 3 empty, 2 busy, 12 parity.
module tb_mio_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int          PB = PAR * 10;
    localparam logic [31:0] SB = (PAR != 0) ? 32'h0000_1000 : 32'h0000_0000;
    localparam logic [2:0]  CN = 3'b000;
    localparam logic [2:0]  CT = 3'b001;
    localparam logic [2:0]  CB = 3'b010;
    localparam logic [2:0]  CS = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   failures = 0;

    mio_uart_tx_if bus();

    mio_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        r;
        logic        we;
        logic [7:0]  wd;
        logic        clr;
        logic [2:0]  chk;
        logic        etx;
        logic        ebusy;
        logic [31:0] est;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int c, input logic r, input logic we, input logic [7:0] wd,
                                input logic clr, input logic [2:0] chk, input logic etx,
                                input logic ebusy, input logic [31:0] est);
        vec_t v;
        v.c = c; v.r = r; v.we = we; v.wd = wd; v.clr = clr;
        v.chk = chk; v.etx = etx; v.ebusy = ebusy; v.est = est;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle c inputs are sampled on the edge closing cycle c; checks look at outputs during cycle c.
    task automatic run_table(input string name);
        int idx = 0;
        int last;
        last = tbl[tbl.size()-1].c;
        base = cyc;
        for (int c = 0; c <= last; c++) begin
            rst = 1'b0; bus.uart_we = 1'b0; bus.uart_wdata = 8'h00; bus.ovf_clr = 1'b0;
            while (idx < tbl.size() && tbl[idx].c == c) begin
                if (tbl[idx].r)   rst = 1'b1;
                if (tbl[idx].we)  begin bus.uart_we = 1'b1; bus.uart_wdata = tbl[idx].wd; end
                if (tbl[idx].clr) bus.ovf_clr = 1'b1;
                if (tbl[idx].chk[0]) check($sformatf("%s c%0d tx", name, c), 32'(bus.tx), 32'(tbl[idx].etx));
                if (tbl[idx].chk[1]) check($sformatf("%s c%0d busy", name, c), 32'(bus.tx_busy), 32'(tbl[idx].ebusy));
                if (tbl[idx].chk[2]) check($sformatf("%s c%0d status", name, c), bus.status_out, tbl[idx].est);
                idx++;
            end
            tick();
        end
        rst = 1'b0; bus.uart_we = 1'b0; bus.ovf_clr = 1'b0;
        tbl.delete();
    endtask

    // Waits (bounded) for a start bit, then samples each bit mid-period.
    task automatic capture_frame(output logic [7:0] b, output int s, output logic p, output logic stop_hi);
        int n = 0;
        b = 8'h00; s = -1; p = 1'b0; stop_hi = 1'b0;
        while (bus.tx !== 1'b0 && n < 400) begin tick(); n++; end
        if (bus.tx !== 1'b0) return;
        s = cyc - base;
        repeat (15) tick();
        for (int i = 0; i < 8; i++) begin
            b[i] = bus.tx;
            if (i < 7) repeat (10) tick();
        end
`ifdef UART_TX_PARITY_EN
        repeat (10) tick();
        p = bus.tx;
`endif
        repeat (10) tick();
        stop_hi = bus.tx;
    endtask

    task automatic monitor_ovf();
        logic [7:0] b;
        int         s;
        logic       p;
        logic       stop_hi;
        int         lows;
        for (int k = 0; k < 5; k++) begin
            capture_frame(b, s, p, stop_hi);
            check($sformatf("ovf frame%0d data", k), 32'(b), 32'h0000_00A0 + 32'(k));
            check($sformatf("ovf frame%0d start", k), 32'(s), 32'(2 + k * (101 + PB)));
            check($sformatf("ovf frame%0d stop", k), 32'(stop_hi), 32'd1);
        end
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.tx !== 1'b1) lows++;
        end
        check("ovf no extra frame", 32'(lows), 32'd0);
        check("ovf final busy", 32'(bus.tx_busy), 32'd0);
        check("ovf final status", bus.status_out, 32'h0000_0048 | SB);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int highs;
        bus.uart_we = 1'b0; bus.uart_wdata = 8'h00; bus.ovf_clr = 1'b0; rst = 1'b1;

        // Reset: three cycles high, then idle outputs.
        add(0, 1, 0, 8'h00, 0, CN, 1, 0, 0);
        add(1, 1, 0, 8'h00, 0, CN, 1, 0, 0);
        add(2, 1, 0, 8'h00, 0, CN, 1, 0, 0);
        add(3, 0, 0, 8'h00, 0, CT|CB|CS, 1, 0, 32'h0000_0008 | SB);
        add(4, 0, 0, 8'h00, 0, CT|CB|CS, 1, 0, 32'h0000_0008 | SB);
        run_table("reset");

        // Single byte 0x55: start cycles 2-11, bits 1,0,1,0,1,0,1,0, stop 92-101.
        add(0,   0, 1, 8'h55, 0, CT|CB|CS, 1, 0, 32'h0000_0008 | SB);
        add(1,   0, 0, 8'h00, 0, CT|CB|CS, 1, 1, 32'h0000_0008 | SB);
        add(2,   0, 0, 8'h00, 0, CT|CB|CS, 0, 1, 32'h0000_0084 | SB);
        add(3,   0, 0, 8'h00, 0, CT|CS,    0, 1, 32'h0000_002C | SB);
        add(11,  0, 0, 8'h00, 0, CT, 0, 1, 0);
        add(12,  0, 0, 8'h00, 0, CT, 1, 1, 0);
        add(21,  0, 0, 8'h00, 0, CT, 1, 1, 0);
        add(22,  0, 0, 8'h00, 0, CT, 0, 1, 0);
        add(32,  0, 0, 8'h00, 0, CT, 1, 1, 0);
        add(42,  0, 0, 8'h00, 0, CT, 0, 1, 0);
        add(52,  0, 0, 8'h00, 0, CT, 1, 1, 0);
        add(62,  0, 0, 8'h00, 0, CT, 0, 1, 0);
        add(72,  0, 0, 8'h00, 0, CT, 1, 1, 0);
        add(82,  0, 0, 8'h00, 0, CT, 0, 1, 0);
        add(91,  0, 0, 8'h00, 0, CT, 0, 1, 0);
        add(92,  0, 0, 8'h00, 0, CT, (PAR != 0) ? 1'b0 : 1'b1, 1, 0);
        add(101 + PB, 0, 0, 8'h00, 0, CT|CB,    1, 1, 0);
        add(102 + PB, 0, 0, 8'h00, 0, CT|CB|CS, 1, 0, 32'h0000_002C | SB);
        add(103 + PB, 0, 0, 8'h00, 0, CS,       1, 0, 32'h0000_0008 | SB);
        run_table("single");

        // Overflow: A0..A5 back to back, A5 dropped; then clear, then clear racing a dropped write.
        add(0,  0, 1, 8'hA0, 0, CS, 1, 0, 32'h0000_0008 | SB);
        add(1,  0, 1, 8'hA1, 0, CN, 1, 0, 0);
        add(2,  0, 1, 8'hA2, 0, CN, 1, 0, 0);
        add(3,  0, 1, 8'hA3, 0, CN, 1, 0, 0);
        add(4,  0, 1, 8'hA4, 0, CN, 1, 0, 0);
        add(5,  0, 1, 8'hA5, 0, CN, 1, 0, 0);
        add(6,  0, 0, 8'h00, 0, CT|CS, 0, 1, 32'h0000_0234 | SB);
        add(7,  0, 0, 8'h00, 0, CS, 0, 1, 32'h0000_0274 | SB);
        add(8,  0, 0, 8'h00, 1, CN, 0, 1, 0);
        add(10, 0, 0, 8'h00, 0, CS, 0, 1, 32'h0000_0234 | SB);
        add(11, 0, 1, 8'hEE, 1, CN, 0, 1, 0);
        add(12, 0, 0, 8'h00, 0, CS, 0, 1, 32'h0000_0234 | SB);
        add(13, 0, 0, 8'h00, 0, CS, 0, 1, 32'h0000_0274 | SB);
        add(14, 0, 0, 8'h00, 0, CB|CS, 0, 1, 32'h0000_0274 | SB);
        base = cyc;
        fork
            run_table("ovf");
            monitor_ovf();
        join

        // Reset during data bit 3 of 0xC3 with two bytes queued.
        add(0,  0, 1, 8'hC3, 1, CN, 1, 0, 0);
        add(1,  0, 1, 8'h11, 0, CN, 1, 0, 0);
        add(2,  0, 1, 8'h22, 0, CN, 1, 0, 0);
        add(44, 0, 0, 8'h00, 0, CT|CS, 0, 1, 32'h0000_0124 | SB);
        add(45, 1, 0, 8'h00, 0, CT|CB, 0, 1, 0);
        add(46, 0, 0, 8'h00, 0, CT|CB|CS, 1, 0, 32'h0000_0008 | SB);
        add(47, 0, 0, 8'h00, 0, CT|CS, 1, 0, 32'h0000_0008 | SB);
        run_table("rstmid");
        lows = 0; highs = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (bus.tx !== 1'b1) lows++;
            if (bus.tx_busy !== 1'b0) highs++;
        end
        check("rstmid line stays idle", 32'(lows), 32'd0);
        check("rstmid busy stays low", 32'(highs), 32'd0);

`ifdef UART_TX_PARITY_EN
        begin
            logic [7:0] b;
            int         s;
            logic       p;
            logic       stop_hi;
            base = cyc;
            bus.uart_we = 1'b1; bus.uart_wdata = 8'h07;
            tick();
            bus.uart_we = 1'b0;
            capture_frame(b, s, p, stop_hi);
            check("parity data", 32'(b), 32'h0000_0007);
            check("parity bit", 32'(p), 32'd1);
            check("parity stop", 32'(stop_hi), 32'd1);
            repeat (4) tick();
            check("parity busy end-1", 32'(bus.tx_busy), 32'd1);
            tick();
            check("parity busy end", 32'(bus.tx_busy), 32'd0);
            check("parity status bit12", 32'(bus.status_out[12]), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
